tower_shooter: RTL
==================

Name: tower_shooter

Overview:
- Consumer end of the car position interface. Reads the car's map location (car_x/car_y), decides when the car is in range of one tower, and fires at it.
- Each shot draws a 4x4 hit flash at the car through the same VGA pixel interface the car uses: plot, coordinates and colour.
- After CAR_HP hits it pulses car_destroyed back to the car datapath, which drives the car's destroyed state.
- One instance sits per placed tower. Its pixel outputs feed the VGA write mux.

Parameters:
- TOWER_X, 8'd60: tower map X.
- TOWER_Y, 7'd40: tower map Y.
- RANGE, 8'd24: maximum per-axis distance, inclusive.
- CAR_HP, 4'd5: hits needed to destroy a car (must be 1..15).
- COOLDOWN_FRAMES, 8'd15: frames between shots.
- CYCLES_PER_FRAME, 21'd1666667: 30 fps at 50 MHz.
- FLASH_COLOUR, 9'b111000000: red, RRRGGGBBB.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: tower placed and active.
- car_valid, input, 1: car is on the map and alive.
- car_x, input, 8: car top-left X on the map.
- car_y, input, 7: car top-left Y on the map.
- game_over, input, 1: freezes firing.
- car_destroyed, output, 1: one-cycle pulse on the kill.
- hits_left, output, 4: hits remaining on the current car.
- plot, output, 1: pixel write strobe.
- coordinates, output, 15: {x[7:0], y[6:0]} to VGA.
- colour, output, 9: pixel colour.
- busy, output, 1: high in FLASH.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - state=IDLE
  - plot=0, car_destroyed=0, busy=0
  - coordinates=0, colour=0
  - hits_left=CAR_HP
  - frame counter=0, cooldown counter=0, flash counter=0
- Frame tick:
  - Free-running counter from 0 to CYCLES_PER_FRAME-1.
  - tick=1 in the cycle the counter wraps to 0.
  - Runs in every state; cleared only by reset.
- In-range:
  - dx = |car_x - TOWER_X|, computed at 9 bits.
  - dy = |car_y - TOWER_Y|, computed at 8 bits.
  - in_range = (dx <= RANGE) && (dy <= RANGE), compared zero-extended. Combinational from current inputs.
- FSM states: IDLE, ARMED, FLASH, COOLDOWN, DEAD.
  - Any state with enable=0: go to IDLE next cycle, plot=0, hits_left=CAR_HP. Highest priority after reset.
  - IDLE: if enable=1, go to ARMED.
  - ARMED, when car_valid && in_range && !game_over in cycle N:
    - Latch lx=car_x, ly=car_y.
    - hits_left decrements by 1.
    - Go to FLASH, flash counter fc=0.
    - First plot=1 at cycle N+1.
  - FLASH lasts exactly 16 cycles (fc 0..15):
    - plot=1.
    - coordinates = {lx + fc[1:0], ly + fc[3:2]}, using 8-bit and 7-bit truncating adds; wrap is permitted.
    - colour = FLASH_COLOUR, busy=1.
    - car_valid, game_over and in_range are ignored until the flash completes.
  - Leaving FLASH, after fc==15:
    - plot=0.
    - If hits_left==0: car_destroyed=1 for exactly one cycle, go to DEAD.
    - Else if car_valid==0: hits_left=CAR_HP, go to ARMED.
    - Else go to COOLDOWN with the cooldown count cleared.
  - COOLDOWN:
    - Count ticks; after COOLDOWN_FRAMES ticks, go to ARMED.
    - car_valid=0 here: hits_left=CAR_HP, go to ARMED immediately (cooldown abandoned).
    - COOLDOWN_FRAMES=0: exit on the first cycle.
  - DEAD:
    - Hold with plot=0.
    - When car_valid=0: hits_left=CAR_HP, go to ARMED. This re-arms the tower for the next car.
- Car leaving while ARMED: if car_valid=0, hits_left reloads to CAR_HP.
- game_over=1 in ARMED: stay in ARMED, no shot. Flash and cooldown already under way complete normally.
- Reset during FLASH: plot drops to 0 the cycle after reset is sampled.

Decomposition:
- Shared package (game_pkg) holds:
  - the colour constants in 9-bit RRRGGGBBB;
  - FRAME_CYCLES_30FPS;
  - the coordinate field widths X_W=8, Y_W=7.
- The FSM state encoding stays local.
- One natural sub-module, frame_tick_gen: parameter CYCLES_PER_FRAME, outputs tick. It is reusable by the car delay logic.

Test Plan:
- Approach from out of range: reset, enable=1, car_valid=1, tower (60,40), RANGE=24, car at (30,40), then car_x=36.
  - No plot while car_x=30 (dx=30).
  - On the car_x=36 cycle N: plot=1 from N+1 to N+16.
  - Coordinates sweep (36,40),(37,40),(38,40),(39,40),(36,41)...(39,43).
  - colour=9'b111000000, hits_left=4.
- Kill sequence: car held at (60,40), CAR_HP=5, COOLDOWN_FRAMES=2, CYCLES_PER_FRAME=10.
  - Exactly 5 flashes, spaced 2 ticks apart.
  - car_destroyed is a single one-cycle pulse after the 5th flash ends.
  - State is DEAD and no further plot occurs.
- Re-arm: from DEAD, drop car_valid for 1 cycle, then car at (50,35).
  - hits_left=5, then a new shot fires and hits_left=4.
- Car leaves mid-flash: drop car_valid at fc=5.
  - Flash completes all 16 pixels.
  - Next state is ARMED with hits_left=5; car_destroyed never pulses.
- game_over freeze: assert game_over with the car in range while ARMED.
  - No plot for 100 cycles.
  - Deasserting game_over fires on the next in-range cycle.
- Reset and enable priority:
  - Assert reset at fc=7: plot=0 next cycle, all outputs at reset values.
  - Drop enable during COOLDOWN: IDLE next cycle, hits_left=5.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: VGA colour palette, frame timing, map coordinate widths.
package game_pkg;

    // Map coordinate field widths as packed onto the VGA bus {x, y}
    localparam int X_W = 8;
    localparam int Y_W = 7;

    // 9-bit RRRGGGBBB colours
    localparam logic [8:0] COLOUR_BLACK = 9'b000_000_000;
    localparam logic [8:0] COLOUR_RED   = 9'b111_000_000;
    localparam logic [8:0] COLOUR_GREEN = 9'b000_111_000;
    localparam logic [8:0] COLOUR_BLUE  = 9'b000_000_111;
    localparam logic [8:0] COLOUR_WHITE = 9'b111_111_111;

    // 30 fps at a 50 MHz system clock
    localparam logic [20:0] FRAME_CYCLES_30FPS = 21'd1666667;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; tick marks the last cycle of each frame,
// i.e. the cycle in which the counter wraps back to zero.
module frame_tick_gen
    import game_pkg::*;
#(
    parameter logic [20:0] CYCLES_PER_FRAME = FRAME_CYCLES_30FPS
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [20:0] count;

    assign tick = (count == CYCLES_PER_FRAME - 21'd1);

    // Count 0 .. CYCLES_PER_FRAME-1 and wrap; only reset clears it
    always_ff @(posedge clk) begin
        if (reset)     count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 21'd1;
    end

endmodule

// File: rtl/tower_shooter.sv
// One placed tower: watches the car position, fires when it is in range,
// draws a 4x4 hit flash through the VGA pixel port and reports the kill.
module tower_shooter
    import game_pkg::*;
#(
    parameter logic [7:0]  TOWER_X          = 8'd60,
    parameter logic [6:0]  TOWER_Y          = 7'd40,
    parameter logic [7:0]  RANGE            = 8'd24,
    parameter logic [3:0]  CAR_HP           = 4'd5,
    parameter logic [7:0]  COOLDOWN_FRAMES  = 8'd15,
    parameter logic [20:0] CYCLES_PER_FRAME = FRAME_CYCLES_30FPS,
    parameter logic [8:0]  FLASH_COLOUR     = COLOUR_RED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         car_valid,
    input  logic [X_W-1:0] car_x,
    input  logic [Y_W-1:0] car_y,
    input  logic         game_over,
    output logic         car_destroyed,
    output logic [3:0]   hits_left,
    output logic         plot,
    output logic [14:0]  coordinates,
    output logic [8:0]   colour,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FLASH,
        S_COOLDOWN,
        S_DEAD
    } state_t;

    state_t         state, state_n;
    logic [3:0]     fc, fc_n;
    logic [7:0]     cd, cd_n;
    logic [X_W-1:0] lx, lx_n;
    logic [Y_W-1:0] ly, ly_n;
    logic [3:0]     hits_n;
    logic           plot_n, destroyed_n, busy_n;
    logic [14:0]    coord_n;
    logic [8:0]     colour_n;
    logic           tick;

    frame_tick_gen #(.CYCLES_PER_FRAME(CYCLES_PER_FRAME)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Per-axis distance; absolute difference avoids signed arithmetic
    logic [8:0] dx;
    logic [7:0] dy;
    logic       in_range;
    assign dx = (car_x >= TOWER_X) ? {1'b0, car_x - TOWER_X} : {1'b0, TOWER_X - car_x};
    assign dy = (car_y >= TOWER_Y) ? {1'b0, car_y - TOWER_Y} : {1'b0, TOWER_Y - car_y};
    assign in_range = (dx <= {1'b0, RANGE}) && (dy <= RANGE);

    // Next flash pixel: column from fc[1:0], row from fc[3:2]; wraps on overflow
    logic [3:0]     fc_inc;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    assign fc_inc = fc + 4'd1;
    assign px = lx + {6'd0, fc_inc[1:0]};
    assign py = ly + {5'd0, fc_inc[3:2]};

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_n     = state;
        fc_n        = fc;
        cd_n        = cd;
        lx_n        = lx;
        ly_n        = ly;
        hits_n      = hits_left;
        plot_n      = 1'b0;
        destroyed_n = 1'b0;
        coord_n     = coordinates;
        colour_n    = colour;

        if (!enable) begin
            state_n = S_IDLE;
            hits_n  = CAR_HP;
        end else begin
            case (state)
                S_IDLE: state_n = S_ARMED;
                S_ARMED: begin
                    if (!car_valid) begin
                        hits_n = CAR_HP;
                    end else if (in_range && !game_over) begin
                        // Pixel 0 is driven straight away so plot rises the next cycle
                        lx_n     = car_x;
                        ly_n     = car_y;
                        hits_n   = hits_left - 4'd1;
                        fc_n     = 4'd0;
                        state_n  = S_FLASH;
                        plot_n   = 1'b1;
                        coord_n  = {car_x, car_y};
                        colour_n = FLASH_COLOUR;
                    end
                end
                S_FLASH: begin
                    if (fc != 4'd15) begin
                        fc_n     = fc_inc;
                        plot_n   = 1'b1;
                        coord_n  = {px, py};
                        colour_n = FLASH_COLOUR;
                    end else if (hits_left == 4'd0) begin
                        destroyed_n = 1'b1;
                        state_n     = S_DEAD;
                    end else if (!car_valid) begin
                        hits_n  = CAR_HP;
                        state_n = S_ARMED;
                    end else begin
                        cd_n    = 8'd0;
                        state_n = S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (!car_valid) begin
                        hits_n  = CAR_HP;
                        state_n = S_ARMED;
                    end else if (cd >= COOLDOWN_FRAMES) begin
                        state_n = S_ARMED;
                    end else if (tick) begin
                        cd_n = cd + 8'd1;
                    end
                end
                S_DEAD: begin
                    if (!car_valid) begin
                        hits_n  = CAR_HP;
                        state_n = S_ARMED;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n == S_FLASH);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            fc            <= '0;
            cd            <= '0;
            lx            <= '0;
            ly            <= '0;
            hits_left     <= CAR_HP;
            plot          <= 1'b0;
            car_destroyed <= 1'b0;
            busy          <= 1'b0;
            coordinates   <= '0;
            colour        <= '0;
        end else begin
            state         <= state_n;
            fc            <= fc_n;
            cd            <= cd_n;
            lx            <= lx_n;
            ly            <= ly_n;
            hits_left     <= hits_n;
            plot          <= plot_n;
            car_destroyed <= destroyed_n;
            busy          <= busy_n;
            coordinates   <= coord_n;
            colour        <= colour_n;
        end
    end

endmodule
